// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - time-multiplexed switch debouncer with prescaled scan FSM
module debounce_scheduler #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 16,
    parameter int STABLE_CNT = 3
) (
    input  logic            clk_amisha,
    input  logic            reset_amisha,
    input  logic            en_amisha,
    input  logic [N_CH-1:0] sw_amisha,
    output logic [N_CH-1:0] db_level_amisha,
    output logic [N_CH-1:0] db_tick_amisha,
    output logic            scan_busy_amisha,
    output logic [2:0]      scan_ch_amisha
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]      CNT_LAST   = 4'(STABLE_CNT - 1);
    localparam logic [2:0]      CH_LAST    = 3'(N_CH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ch_q, ch_d;
    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] level_q, tick_q;
    logic [3:0]      cnt_q [N_CH];
    logic [PW-1:0]   presc_q;
    logic            strobe;

    // Two-flop synchronizer; only sync2_q is ever used for decisions
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_amisha;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler runs only while enabled and freezes otherwise
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            presc_q <= '0;
        end else if (en_amisha) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign strobe = en_amisha && (presc_q == PRESC_LAST);

    // Scan FSM state and channel pointer registers
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Next state: a strobe starts a scan; a scan always runs to the last channel
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                if (ch_q == CH_LAST) begin
                    state_d = IDLE;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // Debounce the serviced channel; tick marks a newly accepted high level
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            tick_q  <= '0;
        end else begin
            tick_q <= '0;
            if (state_q == SCAN) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_q == 3'(i)) begin
                        if (sync2_q[i] == level_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            level_q[i] <= sync2_q[i];
                            cnt_q[i]   <= '0;
                            tick_q[i]  <= sync2_q[i];
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign db_level_amisha  = level_q;
    assign db_tick_amisha   = tick_q;
    assign scan_busy_amisha = (state_q == SCAN);
    assign scan_ch_amisha   = ch_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - self-checking bench for debounce_scheduler
module tb_debounce_scheduler;

    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 16;
    localparam int STABLE_CNT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] db_tick;
    logic            busy;
    logic [2:0]      scan_ch;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    debounce_scheduler #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk_amisha(clk),
        .reset_amisha(reset),
        .en_amisha(en),
        .sw_amisha(sw),
        .db_level_amisha(db_level),
        .db_tick_amisha(db_tick),
        .scan_busy_amisha(busy),
        .scan_ch_amisha(scan_ch)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: enabled-cycle count gives strobes, scan position
    // is an integer slot, each channel keeps a run length of differing samples.
    logic            check_en = 1'b0;
    int              en_cnt;
    int              scan_pos;
    int              run [N_CH];
    logic [N_CH-1:0] m_s1, m_s2, m_lvl, m_tick;

    always @(posedge clk) begin
        logic [N_CH-1:0] s_now;
        logic            strb;
        int              k;
        if (reset) begin
            en_cnt   = 0;
            scan_pos = -1;
            for (int i = 0; i < N_CH; i++) run[i] = 0;
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_tick = '0;
            check_en = 1'b1;
        end else begin
            s_now  = m_s2;
            m_tick = '0;
            if (scan_pos >= 0) begin
                k = scan_pos;
                if (s_now[k] != m_lvl[k]) begin
                    run[k] = run[k] + 1;
                    if (run[k] >= STABLE_CNT) begin
                        m_lvl[k]  = s_now[k];
                        m_tick[k] = s_now[k];
                        run[k]    = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            strb = en && ((en_cnt % TICK_DIV) == TICK_DIV - 1);
            if (en) en_cnt = en_cnt + 1;
            if (scan_pos >= 0) scan_pos = (scan_pos == N_CH - 1) ? -1 : scan_pos + 1;
            else if (strb)     scan_pos = 0;
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    int tick_cnt [N_CH];
    int tick_at  [N_CH];

    // Per-cycle comparison against the model plus tick bookkeeping
    always @(negedge clk) begin
        if (check_en) begin
            check("level", 32'(db_level), 32'(m_lvl));
            check("tick", 32'(db_tick), 32'(m_tick));
            check("busy", 32'(busy), 32'(scan_pos >= 0));
            check("scan_ch", 32'(scan_ch), (scan_pos >= 0) ? 32'(scan_pos) : 32'd0);
            check("tick_onehot", {31'd0, ($countones(db_tick) <= 1)}, 32'd1);
            for (int i = 0; i < N_CH; i++) begin
                if (db_tick[i]) begin
                    tick_cnt[i]++;
                    tick_at[i] = cyc;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic want, output logic ok);
        int n;
        n = 0;
        while (busy !== want && n < 200) begin
            step();
            n++;
        end
        ok = (busy === want);
    endtask

    initial begin
        int   rst_cyc, n, svc, e0;
        int   t0 [N_CH];
        logic ok;
        for (int i = 0; i < N_CH; i++) begin tick_cnt[i] = 0; tick_at[i] = 0; end
        reset = 1'b1; en = 1'b1; sw = '0;

        // Reset state and first-scan latency
        @(posedge clk); #2;
        reset   = 1'b0;
        rst_cyc = cyc;
        step();
        check("rst_outputs", {19'd0, db_level, db_tick, busy, scan_ch}, 32'd0);
        wait_busy(1'b1, ok);
        check("first_scan_found", 32'(ok), 32'd1);
        check("first_scan_latency", 32'(cyc - rst_cyc), 32'd16);
        for (int k = 0; k < N_CH; k++) begin
            check("scan_seq_busy", 32'(busy), 32'd1);
            check("scan_seq_ch", 32'(scan_ch), 32'(k));
            step();
        end
        check("scan_end_busy", 32'(busy), 32'd0);

        // Held press on channel 0: accepted on the third ch0 sample
        t0[0] = tick_cnt[0];
        sw = 4'b0001;
        svc = 0; n = 0;
        while (!db_level[0] && n < 200) begin
            if (busy && scan_ch == 3'd0) svc++;
            step();
            n++;
        end
        check("ch0_samples_to_accept", 32'(svc), 32'd3);
        repeat (3) step();
        check("ch0_tick_count", 32'(tick_cnt[0] - t0[0]), 32'd1);
        check("ch0_level", 32'(db_level), 32'h1);

        // Bouncing channel 1: never accepted
        t0[1] = tick_cnt[1];
        for (int p = 0; p < 10; p++) begin
            wait_busy(1'b1, ok);
            wait_busy(1'b0, ok);
            check("bounce_scan_seen", 32'(ok), 32'd1);
            sw[1] = ~sw[1];
        end
        repeat (20) step();
        check("bounce_level1", 32'(db_level[1]), 32'd0);
        check("bounce_tick1", 32'(tick_cnt[1] - t0[1]), 32'd0);

        // All channels pressed together: four ticks on consecutive cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        sw = 4'b1111;
        for (int i = 0; i < N_CH; i++) t0[i] = tick_cnt[i];
        n = 0;
        while (db_level !== 4'b1111 && n < 200) begin step(); n++; end
        step();
        check("all_level", 32'(db_level), 32'hF);
        for (int i = 0; i < N_CH; i++) check("all_tick_count", 32'(tick_cnt[i] - t0[i]), 32'd1);
        for (int i = 1; i < N_CH; i++) check("all_tick_spacing", 32'(tick_at[i] - tick_at[i-1]), 32'd1);

        // Enable dropped mid-scan: scan finishes, prescaler freezes
        n = 0;
        while (!(busy && scan_ch == 3'd1) && n < 200) begin step(); n++; end
        check("en_drop_found", 32'(busy && scan_ch == 3'd1), 32'd1);
        en = 1'b0;
        step(); check("en_drop_ch2", 32'(scan_ch), 32'd2);
        step(); check("en_drop_ch3", 32'(scan_ch), 32'd3);
        step(); check("en_drop_idle", 32'(busy), 32'd0);
        svc = 0;
        repeat (40) begin step(); if (busy) svc++; end
        check("en_off_no_scan", 32'(svc), 32'd0);
        en = 1'b1;
        e0 = cyc;
        wait_busy(1'b1, ok);
        check("en_resume_latency", 32'(cyc - e0), 32'd15);

        // Reset mid-scan with all levels high
        n = 0;
        while (!(busy && scan_ch == 3'd2) && n < 200) begin step(); n++; end
        check("mid_reset_level", 32'(db_level), 32'hF);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        rst_cyc = cyc;
        check("mid_reset_outputs", {19'd0, db_level, db_tick, busy, scan_ch}, 32'd0);
        wait_busy(1'b1, ok);
        check("mid_reset_latency", 32'(cyc - rst_cyc), 32'd16);
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
